uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive path; the far-end counterpart of the team's 11-bit, LSB-first, idle-high transmit shift register.
- Synchronises the serial line, detects the start bit and samples each bit at mid-bit using 16x oversampling.
- Reassembles the byte and presents it to the host with a ready/acknowledge handshake plus error flags.
- Sits between the external RXD pin and the host register interface.

Parameters:
- BAUD_DIV, 326, clk cycles per oversample tick (clk / (baud*16)); legal range 2..65535.
- OVERSAMPLE, 16, ticks per bit; fixed at 16 (mid-bit = tick 7).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rxd  in  1  serial input, idle high, asynchronous to clk
- rd_ack  in  1  host read strobe; clears rdy and all error flags
- dout  out  8  last received byte
- rdy  out  1  byte available
- ferr  out  1  framing error (stop bit sampled 0)
- perr  out  1  parity error (0 unless UART_RX_PARITY_EN)
- oerr  out  1  overrun (new frame completed while rdy=1)

Behaviour:
- Reset values:
  - dout=8'h00; rdy, ferr, perr, oerr=0.
  - state=IDLE; synchroniser flops=1; tick and bit counters=0.
- Input sync: 2-flop synchroniser on rxd, output rxs. All decisions use rxs only.
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1.
  - tick=1 for one clk when count==BAUD_DIV-1, then wraps to 0.
  - Runs in all states.
- Frame: start(0), d0..d7 LSB first, [parity], stop(1).
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: rxs==0 -> START; clear tick count (tcnt) to 0.
  - START: on tcnt==7 (mid start bit):
    - rxs==0 -> DATA, tcnt=0, bitcnt=0.
    - rxs==1 -> IDLE (glitch rejected; no flags touched).
  - DATA: on tcnt==15:
    - Sample rxs, shift sr <= {rxs, sr[7:1]}; bitcnt++.
    - After the 8th sample -> PARITY if enabled, else STOP.
  - PARITY: on tcnt==15, sample into pbit -> STOP.
  - STOP: on tcnt==15, sample stop bit, then complete the frame:
    - dout<=sr, rdy<=1.
    - ferr<=~rxs; perr per parity check.
    - oerr<=1 if rdy was 1 and rd_ack is not asserted that cycle.
    - stop==1 -> IDLE; stop==0 -> WAIT_IDLE.
  - WAIT_IDLE: hold until rxs==1, then -> IDLE. Prevents a break condition from retriggering.
- tcnt increments only on tick; it is cleared on every state entry.
- Error flags are sticky until rd_ack. A new frame completion ORs new errors in; existing flags are never cleared by it.
- On an overrun, dout is overwritten with the new byte.
- rd_ack:
  - rd_ack without frame completion: rdy, ferr, perr, oerr <= 0 next clk.
  - rd_ack in the same cycle as frame completion: completion wins. rdy=1, flags reflect only the new frame, oerr=0.
- Latency: rdy rises 1 clk after the tick at mid-stop-bit (about 9.5 bit times after the start edge, 10.5 with parity).
- Reset mid-frame: immediate return to IDLE with all reset values; the partial byte is discarded.
- rxd held low from reset release: START then DATA. A frame of all zeros with stop=0 gives dout=00, ferr=1; the block then sits in WAIT_IDLE.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - PARITY state present; 11-bit frame, matching the transmitter frame length.
  - Even parity: perr = ^{sr, pbit}.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; 10-bit frame.
  - perr tied to 0 and its logic removed.

Test Plan (BAUD_DIV=4, bit = 64 clk):
- Send 0xA5 (parity 0 when enabled), stop=1 -> rdy=1, dout=8'hA5, ferr=perr=oerr=0; rd_ack -> rdy=0 next clk.
- Low pulse of 20 clk (under the 32-clk half bit) on idle line -> state back to IDLE, rdy stays 0, no flags.
- Send 0x3C with stop=0, then line high -> dout=8'h3C, rdy=1, ferr=1; next frame 0x11 received normally after the line returns high.
- Send 0x01 then 0x02 with no rd_ack -> dout=8'h02, rdy=1, oerr=1; rd_ack clears all flags.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> perr=1, dout=8'h07.
- Assert rst during d3 of a frame, release, send 0x5A -> only dout=8'h5A reported, no errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// Host-side bundle for the UART receiver: serial pin, read strobe, received byte and status flags.
interface uart_rx_if;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] dout;
  logic       rdy;
  logic       ferr;
  logic       perr;
  logic       oerr;

  // Host / line driver side
  modport master (
    output rxd,
    output rd_ack,
    input  dout,
    input  rdy,
    input  ferr,
    input  perr,
    input  oerr
  );

  // Receiver side
  modport slave (
    input  rxd,
    input  rd_ack,
    output dout,
    output rdy,
    output ferr,
    output perr,
    output oerr
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, idle-high line with ready/ack host handshake.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN (11-bit frame);
// without it the frame is 10 bits and perr is tied low.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 326
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TCNT_W     = 4;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned LAST_TICK  = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_rxs;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic              w_tick;
  logic              w_at_mid;
  logic              w_at_end;
  logic              w_done;
  state_t            r_state;
  logic [TCNT_W-1:0] r_tcnt;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_sr;
  logic [7:0]        r_dout;
  logic              r_rdy;
  logic              r_ferr;
  logic              r_oerr;
`ifdef UART_RX_PARITY_EN
  logic              r_pbit;
  logic              r_perr;
`endif

  assign w_rxs    = r_sync2;
  assign w_tick   = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign w_at_mid = w_tick && (r_tcnt == TCNT_W'(MID_TICK));
  assign w_at_end = w_tick && (r_tcnt == TCNT_W'(LAST_TICK));
  assign w_done   = (r_state == S_STOP) && w_at_end;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running oversample tick generator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
    end else if (w_tick) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + CNT_W'(1);
    end
  end

  // Frame state machine; tick count restarts on every state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tcnt   <= '0;
      r_bitcnt <= '0;
      r_sr     <= '0;
`ifdef UART_RX_PARITY_EN
      r_pbit   <= 1'b0;
`endif
    end else begin
      if (w_tick) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_tcnt  <= '0;
          end
        end
        S_START: begin
          if (w_at_mid) begin
            r_tcnt <= '0;
            if (!w_rxs) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_at_end) begin
            r_sr     <= {w_rxs, r_sr[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_tcnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_at_end) begin
            r_pbit  <= w_rxs;
            r_state <= S_STOP;
            r_tcnt  <= '0;
          end
        end
`endif
        S_STOP: begin
          if (w_at_end) begin
            r_tcnt  <= '0;
            r_state <= w_rxs ? S_IDLE : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          // A held-low line (break) must return high before a new start is accepted
          if (w_rxs) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tcnt  <= '0;
        end
      endcase
    end
  end

  // Host handshake: completion sets rdy and ORs in sticky errors; rd_ack clears, completion wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
    end else if (w_done) begin
      r_dout <= r_sr;
      r_rdy  <= 1'b1;
      r_ferr <= (r_ferr & ~bus.rd_ack) | ~w_rxs;
      r_oerr <= (r_oerr | r_rdy) & ~bus.rd_ack;
`ifdef UART_RX_PARITY_EN
      r_perr <= (r_perr & ~bus.rd_ack) | (^{r_sr, r_pbit});
`endif
    end else if (bus.rd_ack) begin
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
    end
  end

  assign bus.dout = r_dout;
  assign bus.rdy  = r_rdy;
  assign bus.ferr = r_ferr;
  assign bus.oerr = r_oerr;
`ifdef UART_RX_PARITY_EN
  assign bus.perr = r_perr;
`else
  assign bus.perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV=4 (one bit = 64 clk); honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_rx_if bus ();

  uart_rx #(.BAUD_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  // Drive one serial bit for a full bit time; called at a falling edge
  task automatic drive_bit(input logic v);
    bus.rxd = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Full frame with correct even parity (when enabled) and chosen stop bit, line left idle
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
    bus.rxd = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.dout); end
    checks++; if (bus.rdy  !== 1'b0)  begin errors++; $display("FAIL reset_rdy got %b exp 0", bus.rdy); end
    checks++; if (bus.ferr !== 1'b0)  begin errors++; $display("FAIL reset_ferr got %b exp 0", bus.ferr); end
    checks++; if (bus.perr !== 1'b0)  begin errors++; $display("FAIL reset_perr got %b exp 0", bus.perr); end
    checks++; if (bus.oerr !== 1'b0)  begin errors++; $display("FAIL reset_oerr got %b exp 0", bus.oerr); end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1);
    checks++; if (bus.rdy  !== 1'b1)  begin errors++; $display("FAIL basic_rdy got %b exp 1", bus.rdy); end
    checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", bus.dout); end
    checks++; if (bus.ferr !== 1'b0)  begin errors++; $display("FAIL basic_ferr got %b exp 0", bus.ferr); end
    checks++; if (bus.perr !== 1'b0)  begin errors++; $display("FAIL basic_perr got %b exp 0", bus.perr); end
    checks++; if (bus.oerr !== 1'b0)  begin errors++; $display("FAIL basic_oerr got %b exp 0", bus.oerr); end
    pulse_ack();
    checks++; if (bus.rdy  !== 1'b0)  begin errors++; $display("FAIL basic_ack_rdy got %b exp 0", bus.rdy); end
  endtask

  task automatic test_glitch();
    bus.rxd = 1'b0;
    repeat (20) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    checks++; if (bus.rdy  !== 1'b0) begin errors++; $display("FAIL glitch_rdy got %b exp 0", bus.rdy); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL glitch_ferr got %b exp 0", bus.ferr); end
    checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout got %h exp a5", bus.dout); end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL frame_dout got %h exp 3c", bus.dout); end
    checks++; if (bus.rdy  !== 1'b1)  begin errors++; $display("FAIL frame_rdy got %b exp 1", bus.rdy); end
    checks++; if (bus.ferr !== 1'b1)  begin errors++; $display("FAIL frame_ferr got %b exp 1", bus.ferr); end
    checks++; if (bus.oerr !== 1'b0)  begin errors++; $display("FAIL frame_oerr got %b exp 0", bus.oerr); end
    pulse_ack();
    checks++; if (bus.ferr !== 1'b0)  begin errors++; $display("FAIL frame_ack_ferr got %b exp 0", bus.ferr); end
    send_frame(8'h11, 1'b1);
    checks++; if (bus.dout !== 8'h11) begin errors++; $display("FAIL frame_next_dout got %h exp 11", bus.dout); end
    checks++; if (bus.rdy  !== 1'b1)  begin errors++; $display("FAIL frame_next_rdy got %b exp 1", bus.rdy); end
    checks++; if (bus.ferr !== 1'b0)  begin errors++; $display("FAIL frame_next_ferr got %b exp 0", bus.ferr); end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    checks++; if (bus.dout !== 8'h02) begin errors++; $display("FAIL b2b_dout got %h exp 02", bus.dout); end
    checks++; if (bus.rdy  !== 1'b1)  begin errors++; $display("FAIL b2b_rdy got %b exp 1", bus.rdy); end
    checks++; if (bus.oerr !== 1'b1)  begin errors++; $display("FAIL b2b_oerr got %b exp 1", bus.oerr); end
    checks++; if (bus.ferr !== 1'b0)  begin errors++; $display("FAIL b2b_ferr got %b exp 0", bus.ferr); end
    pulse_ack();
    checks++; if (bus.rdy  !== 1'b0)  begin errors++; $display("FAIL b2b_ack_rdy got %b exp 0", bus.rdy); end
    checks++; if (bus.oerr !== 1'b0)  begin errors++; $display("FAIL b2b_ack_oerr got %b exp 0", bus.oerr); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    bus.rxd = 1'b1;
    checks++; if (bus.perr !== 1'b1)  begin errors++; $display("FAIL parity_perr got %b exp 1", bus.perr); end
`else
    send_frame(8'h07, 1'b1);
    checks++; if (bus.perr !== 1'b0)  begin errors++; $display("FAIL parity_perr got %b exp 0", bus.perr); end
`endif
    checks++; if (bus.dout !== 8'h07) begin errors++; $display("FAIL parity_dout got %h exp 07", bus.dout); end
    checks++; if (bus.rdy  !== 1'b1)  begin errors++; $display("FAIL parity_rdy got %b exp 1", bus.rdy); end
    pulse_ack();
    checks++; if (bus.perr !== 1'b0)  begin errors++; $display("FAIL parity_ack_perr got %b exp 0", bus.perr); end
  endtask

  task automatic test_reset_midframe();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    bus.rxd = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (bus.rdy  !== 1'b0)  begin errors++; $display("FAIL rstmid_rdy got %b exp 0", bus.rdy); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got %h exp 00", bus.dout); end
    send_frame(8'h5A, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (bus.dout !== 8'h5A) begin errors++; $display("FAIL rstmid_new_dout got %h exp 5a", bus.dout); end
    checks++; if (bus.rdy  !== 1'b1)  begin errors++; $display("FAIL rstmid_new_rdy got %b exp 1", bus.rdy); end
    checks++; if ({bus.ferr, bus.perr, bus.oerr} !== 3'b000) begin
      errors++; $display("FAIL rstmid_flags got %b exp 000", {bus.ferr, bus.perr, bus.oerr});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.rxd    = 1'b1;
    bus.rd_ack = 1'b0;
    repeat (5) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
